ex_stage_mem_reg: RTL and testbench

Execute stage of the 5-stage pipeline, directly downstream of the ID/EX pipeline register. It takes the registered ID/EX instruction, operands and control bits, and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It runs the ALU, holds the carry and zero flags, and registers results and control into the EX/MEM pipeline register (PR3_*). It supports hold (stall) and flush (bubble).

---
 rtl/ex_stage_mem_reg_if.sv | 104 ++++++++++
 rtl/ex_stage_mem_reg.sv | 252 +++++++++++++++++++++++++
 tb/tb_ex_stage_mem_reg.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_mem_reg_if.sv
// Bundle between ID/EX, the execute stage and EX/MEM.
// master drives PR2 and MEM/WB side, slave owns PR3 and flags.
interface ex_stage_mem_reg_if #(
  parameter int WORD_LEN        = 8,
  parameter int INSTRUCTION_LEN = 19,
  parameter int REG_ADDR_LEN    = 3
);

  logic [INSTRUCTION_LEN-1:0] PR2_instruction;
  logic [WORD_LEN-1:0]        PR2_RF_out1;
  logic [WORD_LEN-1:0]        PR2_RF_out2;
  logic [3:0]                 PR2_ALU_op;
  logic                       PR2_sel_ALU_src_reg2;
  logic                       PR2_sel_ALU_src_const;
  logic                       PR2_sel_ALU_src_shift_count;
  logic                       PR2_sel_Cin_alu;
  logic                       PR2_MEM_write;
  logic                       PR2_MEM_read;
  logic                       PR2_RF_write_en;
  logic                       PR2_sel_RF_write_src_ALU;
  logic                       PR2_sel_RF_write_src_MEM;

  logic                       hold;
  logic                       flush;

  logic [REG_ADDR_LEN-1:0]    MEMWB_rd;
  logic                       MEMWB_write_en;
  logic [WORD_LEN-1:0]        MEMWB_data;

  logic [WORD_LEN-1:0]        PR3_ALU_result;
  logic [WORD_LEN-1:0]        PR3_store_data;
  logic [REG_ADDR_LEN-1:0]    PR3_rd;
  logic                       PR3_MEM_write;
  logic                       PR3_MEM_read;
  logic                       PR3_RF_write_en;
  logic                       PR3_sel_RF_write_src_ALU;
  logic                       PR3_sel_RF_write_src_MEM;

  logic                       carry_flag;
  logic                       zero_flag;

  modport master (
    output PR2_instruction,
    output PR2_RF_out1,
    output PR2_RF_out2,
    output PR2_ALU_op,
    output PR2_sel_ALU_src_reg2,
    output PR2_sel_ALU_src_const,
    output PR2_sel_ALU_src_shift_count,
    output PR2_sel_Cin_alu,
    output PR2_MEM_write,
    output PR2_MEM_read,
    output PR2_RF_write_en,
    output PR2_sel_RF_write_src_ALU,
    output PR2_sel_RF_write_src_MEM,
    output hold,
    output flush,
    output MEMWB_rd,
    output MEMWB_write_en,
    output MEMWB_data,
    input  PR3_ALU_result,
    input  PR3_store_data,
    input  PR3_rd,
    input  PR3_MEM_write,
    input  PR3_MEM_read,
    input  PR3_RF_write_en,
    input  PR3_sel_RF_write_src_ALU,
    input  PR3_sel_RF_write_src_MEM,
    input  carry_flag,
    input  zero_flag
  );

  modport slave (
    input  PR2_instruction,
    input  PR2_RF_out1,
    input  PR2_RF_out2,
    input  PR2_ALU_op,
    input  PR2_sel_ALU_src_reg2,
    input  PR2_sel_ALU_src_const,
    input  PR2_sel_ALU_src_shift_count,
    input  PR2_sel_Cin_alu,
    input  PR2_MEM_write,
    input  PR2_MEM_read,
    input  PR2_RF_write_en,
    input  PR2_sel_RF_write_src_ALU,
    input  PR2_sel_RF_write_src_MEM,
    input  hold,
    input  flush,
    input  MEMWB_rd,
    input  MEMWB_write_en,
    input  MEMWB_data,
    output PR3_ALU_result,
    output PR3_store_data,
    output PR3_rd,
    output PR3_MEM_write,
    output PR3_MEM_read,
    output PR3_RF_write_en,
    output PR3_sel_RF_write_src_ALU,
    output PR3_sel_RF_write_src_MEM,
    output carry_flag,
    output zero_flag
  );

endinterface

// File: rtl/ex_stage_mem_reg.sv
// Execute stage: operand forwarding, ALU with carry/zero flags,
// and the EX/MEM pipeline register with hold and bubble insertion.
module ex_stage_mem_reg #(
  parameter int WORD_LEN        = 8,
  parameter int INSTRUCTION_LEN = 19,
  parameter int REG_ADDR_LEN    = 3
) (
  input  logic              clk,
  input  logic              rst,
  ex_stage_mem_reg_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;

  typedef struct packed {
    logic [WORD_LEN-1:0]     alu_result;
    logic [WORD_LEN-1:0]     store_data;
    logic [REG_ADDR_LEN-1:0] rd;
    logic                    mem_write;
    logic                    mem_read;
    logic                    rf_write_en;
    logic                    src_alu;
    logic                    src_mem;
  } ex_mem_t;

  ex_mem_t pr3_q;
  ex_mem_t pr3_d;
  ex_mem_t bubble;
  logic    carry_q;
  logic    zero_q;

  logic [REG_ADDR_LEN-1:0] rd;
  logic [REG_ADDR_LEN-1:0] rs;
  logic [REG_ADDR_LEN-1:0] rt;
  logic [7:0]              imm;
  logic [2:0]              shamt;
  logic [3:0]              op;

  assign rd    = bus.PR2_instruction[13:11];
  assign rs    = bus.PR2_instruction[10:8];
  assign rt    = bus.PR2_instruction[7:5];
  assign imm   = bus.PR2_instruction[7:0];
  assign shamt = bus.PR2_instruction[7:5];
  assign op    = bus.PR2_ALU_op;

  logic unused_instr;
  assign unused_instr =
    ^bus.PR2_instruction[INSTRUCTION_LEN-1:14];

  // A load in EX/MEM has no value yet; ID stalls that case.
  logic ex_fwd_ok;
  logic ex_hit_a;
  logic ex_hit_b;
  logic wb_hit_a;
  logic wb_hit_b;

  assign ex_fwd_ok = pr3_q.rf_write_en
                   & ~pr3_q.mem_read;
  assign ex_hit_a  = ex_fwd_ok
                   && (pr3_q.rd == rs);
  assign ex_hit_b  = ex_fwd_ok
                   && (pr3_q.rd == rt);
  assign wb_hit_a  = bus.MEMWB_write_en
                   && (bus.MEMWB_rd == rs);
  assign wb_hit_b  = bus.MEMWB_write_en
                   && (bus.MEMWB_rd == rt);

  logic [WORD_LEN-1:0] opa;
  logic [WORD_LEN-1:0] rt_fwd;

  always_comb begin
    opa = bus.PR2_RF_out1;
    if (ex_hit_a) begin
      opa = pr3_q.alu_result;
    end else if (wb_hit_a) begin
      opa = bus.MEMWB_data;
    end
  end

  always_comb begin
    rt_fwd = bus.PR2_RF_out2;
    if (ex_hit_b) begin
      rt_fwd = pr3_q.alu_result;
    end else if (wb_hit_b) begin
      rt_fwd = bus.MEMWB_data;
    end
  end

  // Selects are masked down to one-hot in priority order.
  logic sel_const;
  logic sel_shift;
  logic sel_reg2;

  assign sel_const = bus.PR2_sel_ALU_src_const;
  assign sel_shift = bus.PR2_sel_ALU_src_shift_count
                   & ~sel_const;
  assign sel_reg2  = bus.PR2_sel_ALU_src_reg2
                   & ~sel_const
                   & ~bus.PR2_sel_ALU_src_shift_count;

  logic [WORD_LEN-1:0] opb;

  always_comb begin
    opb = '0;
    unique case (1'b1)
      sel_const: opb = WORD_LEN'(imm);
      sel_shift: opb = WORD_LEN'(shamt);
      sel_reg2:  opb = rt_fwd;
      default:   opb = '0;
    endcase
  end

  logic              cin;
  logic [WORD_LEN:0] a_w;
  logic [WORD_LEN:0] b_w;
  logic [WORD_LEN:0] nb_w;
  logic [WORD_LEN:0] cin_w;
  logic [WORD_LEN:0] one_w;
  logic [2:0]        amt;

  assign cin   = bus.PR2_sel_Cin_alu & carry_q;
  assign a_w   = {1'b0, opa};
  assign b_w   = {1'b0, opb};
  assign nb_w  = {1'b0, ~opb};
  assign cin_w = {{WORD_LEN{1'b0}}, cin};
  assign one_w = {{WORD_LEN{1'b0}}, 1'b1};
  assign amt   = opb[2:0];

  logic [WORD_LEN:0]   sum;
  logic [WORD_LEN-1:0] result;
  logic                upd_c;
  logic                upd_z;

  always_comb begin
    sum    = '0;
    result = '0;
    upd_c  = 1'b0;
    upd_z  = 1'b0;
    case (op)
      OP_ADD: begin
        sum   = a_w + b_w;
        upd_c = 1'b1;
      end
      OP_ADC: begin
        sum   = a_w + b_w + cin_w;
        upd_c = 1'b1;
      end
      OP_SUB: begin
        sum   = a_w + nb_w + one_w;
        upd_c = 1'b1;
      end
      OP_SBC: begin
        sum   = a_w + nb_w + cin_w;
        upd_c = 1'b1;
      end
      OP_AND: result = opa & opb;
      OP_OR:  result = opa | opb;
      OP_XOR: result = opa ^ opb;
      OP_MOV: result = opb;
      OP_SHL: result = opa << amt;
      OP_SHR: result = opa >> amt;
      OP_ROL: begin
        if (amt == 3'd0) begin
          result = opa;
        end else begin
          result = (opa << amt)
                 | (opa >> (WORD_LEN - int'(amt)));
        end
      end
      OP_ROR: begin
        if (amt == 3'd0) begin
          result = opa;
        end else begin
          result = (opa >> amt)
                 | (opa << (WORD_LEN - int'(amt)));
        end
      end
      default: result = '0;
    endcase
    if (upd_c) begin
      result = sum[WORD_LEN-1:0];
    end
    upd_z = (op <= OP_ROR);
  end

  logic zero_res;
  assign zero_res = (result == '0);

  always_comb begin
    pr3_d.alu_result  = result;
    pr3_d.store_data  = rt_fwd;
    pr3_d.rd          = rd;
    pr3_d.mem_write   = bus.PR2_MEM_write;
    pr3_d.mem_read    = bus.PR2_MEM_read;
    pr3_d.rf_write_en = bus.PR2_RF_write_en;
    pr3_d.src_alu     = bus.PR2_sel_RF_write_src_ALU;
    pr3_d.src_mem     = bus.PR2_sel_RF_write_src_MEM;
  end

  // A bubble still carries the data fields; only control is killed.
  always_comb begin
    bubble             = pr3_d;
    bubble.mem_write   = 1'b0;
    bubble.mem_read    = 1'b0;
    bubble.rf_write_en = 1'b0;
    bubble.src_alu     = 1'b0;
    bubble.src_mem     = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr3_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (bus.flush) begin
      pr3_q <= bubble;
    end else if (!bus.hold) begin
      pr3_q <= pr3_d;
      if (bus.PR2_RF_write_en) begin
        if (upd_c) begin
          carry_q <= sum[WORD_LEN];
        end
        if (upd_z) begin
          zero_q <= zero_res;
        end
      end
    end
  end

  assign bus.PR3_ALU_result           = pr3_q.alu_result;
  assign bus.PR3_store_data           = pr3_q.store_data;
  assign bus.PR3_rd                   = pr3_q.rd;
  assign bus.PR3_MEM_write            = pr3_q.mem_write;
  assign bus.PR3_MEM_read             = pr3_q.mem_read;
  assign bus.PR3_RF_write_en          = pr3_q.rf_write_en;
  assign bus.PR3_sel_RF_write_src_ALU = pr3_q.src_alu;
  assign bus.PR3_sel_RF_write_src_MEM = pr3_q.src_mem;
  assign bus.carry_flag               = carry_q;
  assign bus.zero_flag                = zero_q;

endmodule

// File: tb/tb_ex_stage_mem_reg.sv
// Bench for ex_stage_mem_reg: directed table of pipeline
// sequences, then random traffic against a behavioural model.
module tb_ex_stage_mem_reg;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_stage_mem_reg_if #(
    .WORD_LEN(8),
    .INSTRUCTION_LEN(19),
    .REG_ADDR_LEN(3)
  ) bus ();

  ex_stage_mem_reg #(
    .WORD_LEN(8),
    .INSTRUCTION_LEN(19),
    .REG_ADDR_LEN(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rst;
    logic        hold;
    logic        flush;
    logic [3:0]  op;
    logic [18:0] instr;
    logic [7:0]  rf1;
    logic [7:0]  rf2;
    logic [2:0]  bsel;
    logic        cin;
    logic [4:0]  ctrl;
    logic [2:0]  wbrd;
    logic        wbwe;
    logic [7:0]  wbdata;
    logic [7:0]  e_res;
    logic [7:0]  e_store;
    logic [2:0]  e_rd;
    logic [4:0]  e_ctrl;
    logic        e_c;
    logic        e_z;
  } vec_t;

  // ctrl = {mem_write, mem_read, rf_we, src_alu, src_mem}
  localparam logic [4:0] CA = 5'b00110;
  localparam logic [4:0] CL = 5'b01101;
  localparam logic [4:0] CS = 5'b10000;
  localparam logic [4:0] C0 = 5'b00000;
  // bsel = {const, shift, reg2}
  localparam logic [2:0] BR = 3'b001;
  localparam logic [2:0] BS = 3'b010;
  localparam logic [2:0] BC = 3'b100;
  localparam logic [2:0] B0 = 3'b000;
  localparam int NT = 22;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_res   = '0;
  logic [7:0] m_store = '0;
  logic [2:0] m_rd    = '0;
  logic [4:0] m_ctrl  = '0;
  logic       m_c     = 1'b0;
  logic       m_z     = 1'b0;

  vec_t tbl [NT];

  function automatic vec_t mk(
    input logic r, input logic hd, input logic fl,
    input logic [3:0] op, input logic [2:0] rd,
    input logic [2:0] rs, input logic [7:0] imm,
    input logic [7:0] rf1, input logic [7:0] rf2,
    input logic [2:0] bsel, input logic cin,
    input logic [4:0] ctrl, input logic [2:0] wbrd,
    input logic wbwe, input logic [7:0] wbdata,
    input logic [7:0] eres, input logic [7:0] estore,
    input logic [2:0] erd, input logic [4:0] ectrl,
    input logic ec, input logic ez);
    vec_t v;
    v.rst = r; v.hold = hd; v.flush = fl;
    v.op = op; v.instr = {5'b0, rd, rs, imm};
    v.rf1 = rf1; v.rf2 = rf2; v.bsel = bsel;
    v.cin = cin; v.ctrl = ctrl;
    v.wbrd = wbrd; v.wbwe = wbwe; v.wbdata = wbdata;
    v.e_res = eres; v.e_store = estore; v.e_rd = erd;
    v.e_ctrl = ectrl; v.e_c = ec; v.e_z = ez;
    return v;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    v = mk(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 8'h0,
           8'h0, 8'h0, B0, 1'b0, C0, 3'd0, 1'b0, 8'h0,
           8'h0, 8'h0, 3'd0, C0, 1'b0, 1'b0);
    v.rst    = ($urandom_range(0, 39) == 0);
    v.hold   = ($urandom_range(0, 7) == 0);
    v.flush  = ($urandom_range(0, 9) == 0);
    v.op     = 4'($urandom_range(0, 15));
    v.instr  = 19'($urandom);
    v.rf1    = 8'($urandom);
    v.rf2    = 8'($urandom);
    v.bsel   = 3'($urandom);
    v.cin    = 1'($urandom);
    v.ctrl   = 5'($urandom);
    v.wbrd   = 3'($urandom);
    v.wbwe   = 1'($urandom);
    v.wbdata = 8'($urandom);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst                             = v.rst;
    bus.hold                        = v.hold;
    bus.flush                       = v.flush;
    bus.PR2_instruction             = v.instr;
    bus.PR2_RF_out1                 = v.rf1;
    bus.PR2_RF_out2                 = v.rf2;
    bus.PR2_ALU_op                  = v.op;
    bus.PR2_sel_ALU_src_const       = v.bsel[2];
    bus.PR2_sel_ALU_src_shift_count = v.bsel[1];
    bus.PR2_sel_ALU_src_reg2        = v.bsel[0];
    bus.PR2_sel_Cin_alu             = v.cin;
    {bus.PR2_MEM_write, bus.PR2_MEM_read,
     bus.PR2_RF_write_en, bus.PR2_sel_RF_write_src_ALU,
     bus.PR2_sel_RF_write_src_MEM} = v.ctrl;
    bus.MEMWB_rd                    = v.wbrd;
    bus.MEMWB_write_en              = v.wbwe;
    bus.MEMWB_data                  = v.wbdata;
  endtask

  // Newest producer wins; a pending load in EX/MEM cannot supply.
  function automatic logic [7:0] fwd(
    input logic [2:0] idx, input logic [7:0] rf,
    input vec_t v);
    if (m_ctrl[2] && !m_ctrl[3] && m_rd == idx)
      return m_res;
    if (v.wbwe && v.wbrd == idx)
      return v.wbdata;
    return rf;
  endfunction

  task automatic model_step(input vec_t v);
    int a, b, s, n, r, op;
    logic [7:0] st;
    a  = int'(fwd(v.instr[10:8], v.rf1, v));
    st = fwd(v.instr[7:5], v.rf2, v);
    if (v.bsel[2])      b = int'(v.instr[7:0]);
    else if (v.bsel[1]) b = int'(v.instr[7:5]);
    else if (v.bsel[0]) b = int'(st);
    else                b = 0;
    n  = b % 8;
    op = int'(v.op);
    s  = 0;
    r  = 0;
    case (op)
      0:  s = a + b;
      1:  s = a + b + int'(v.cin & m_c);
      2:  s = a + (255 - b) + 1;
      3:  s = a + (255 - b) + int'(v.cin & m_c);
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = b;
      8:  r = (a << n) % 256;
      9:  r = a >> n;
      10: r = ((a << n) | (a >> (8 - n))) % 256;
      11: r = ((a >> n) | (a << (8 - n))) % 256;
      default: r = 0;
    endcase
    if (op <= 3) r = s % 256;
    if (v.rst) begin
      m_res = '0; m_store = '0; m_rd = '0;
      m_ctrl = '0; m_c = 1'b0; m_z = 1'b0;
    end else if (v.flush) begin
      m_res = 8'(r); m_store = st;
      m_rd = v.instr[13:11]; m_ctrl = '0;
    end else if (!v.hold) begin
      m_res = 8'(r); m_store = st;
      m_rd = v.instr[13:11]; m_ctrl = v.ctrl;
      if (v.ctrl[2]) begin
        if (op <= 3)  m_c = (s > 255);
        if (op <= 11) m_z = (r == 0);
      end
    end
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h",
               nm, row, act, exp);
    end
  endtask

  task automatic check_all(input int row,
    input logic [7:0] eres, input logic [7:0] estore,
    input logic [2:0] erd, input logic [4:0] ectrl,
    input logic ec, input logic ez);
    logic [4:0] ctrl;
    ctrl = {bus.PR3_MEM_write, bus.PR3_MEM_read,
            bus.PR3_RF_write_en, bus.PR3_sel_RF_write_src_ALU,
            bus.PR3_sel_RF_write_src_MEM};
    chk("alu_result", row, bus.PR3_ALU_result, eres);
    chk("store_data", row, bus.PR3_store_data, estore);
    chk("rd", row, 8'(bus.PR3_rd), 8'(erd));
    chk("ctrl", row, 8'(ctrl), 8'(ectrl));
    chk("carry", row, 8'(bus.carry_flag), 8'(ec));
    chk("zero", row, 8'(bus.zero_flag), 8'(ez));
  endtask

  initial begin
    // rst hd fl op rd rs imm rf1 rf2 bsel cin ctrl wbrd wbwe wbd
    //   | res store rd ctrl c z
    tbl[0]  = mk(1'b1,1'b0,1'b0,4'd0,3'd5,3'd1,8'h23,8'h11,8'h22,BR,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h00,8'h00,3'd0,C0,1'b0,1'b0);
    tbl[1]  = mk(1'b1,1'b0,1'b0,4'd1,3'd6,3'd7,8'hE4,8'hFF,8'hFF,BR,1'b1,CL,3'd7,1'b1,8'h99,
                 8'h00,8'h00,3'd0,C0,1'b0,1'b0);
    tbl[2]  = mk(1'b0,1'b0,1'b0,4'd0,3'd1,3'd2,8'h00,8'h03,8'h04,BR,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h07,8'h04,3'd1,CA,1'b0,1'b0);
    tbl[3]  = mk(1'b0,1'b0,1'b0,4'd0,3'd3,3'd4,8'h40,8'hFF,8'h01,BR,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h00,8'h01,3'd3,CA,1'b1,1'b1);
    tbl[4]  = mk(1'b0,1'b0,1'b0,4'd1,3'd4,3'd5,8'hC0,8'h10,8'h20,BR,1'b1,CA,3'd0,1'b0,8'h00,
                 8'h31,8'h20,3'd4,CA,1'b0,1'b0);
    tbl[5]  = mk(1'b0,1'b0,1'b0,4'd7,3'd2,3'd0,8'h55,8'h00,8'h00,BC,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h55,8'h00,3'd2,CA,1'b0,1'b0);
    tbl[6]  = mk(1'b0,1'b0,1'b0,4'd5,3'd7,3'd2,8'h00,8'h11,8'h0F,B0,1'b0,CA,3'd2,1'b1,8'hAA,
                 8'h55,8'h0F,3'd7,CA,1'b0,1'b0);
    tbl[7]  = mk(1'b0,1'b0,1'b0,4'd0,3'd2,3'd0,8'h05,8'h10,8'h00,BC,1'b0,CL,3'd0,1'b0,8'h00,
                 8'h15,8'h00,3'd2,CL,1'b0,1'b0);
    tbl[8]  = mk(1'b0,1'b0,1'b0,4'd5,3'd6,3'd2,8'h00,8'h33,8'h44,B0,1'b0,CA,3'd2,1'b1,8'hAA,
                 8'hAA,8'h44,3'd6,CA,1'b0,1'b0);
    tbl[9]  = mk(1'b0,1'b1,1'b0,4'd0,3'd1,3'd1,8'h00,8'h01,8'h02,BR,1'b0,CA,3'd0,1'b0,8'h00,
                 8'hAA,8'h44,3'd6,CA,1'b0,1'b0);
    tbl[10] = mk(1'b0,1'b1,1'b0,4'd2,3'd2,3'd3,8'h20,8'hFF,8'hFF,BR,1'b0,CA,3'd6,1'b1,8'h00,
                 8'hAA,8'h44,3'd6,CA,1'b0,1'b0);
    tbl[11] = mk(1'b0,1'b1,1'b0,4'd0,3'd3,3'd6,8'hE0,8'h80,8'h80,BR,1'b0,CA,3'd0,1'b0,8'h00,
                 8'hAA,8'h44,3'd6,CA,1'b0,1'b0);
    tbl[12] = mk(1'b0,1'b0,1'b0,4'd0,3'd1,3'd3,8'h00,8'h01,8'h01,BR,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h02,8'h01,3'd1,CA,1'b0,1'b0);
    tbl[13] = mk(1'b0,1'b0,1'b1,4'd0,3'd5,3'd4,8'h05,8'h80,8'h99,BC,1'b0,CS,3'd0,1'b0,8'h00,
                 8'h85,8'h99,3'd5,C0,1'b0,1'b0);
    tbl[14] = mk(1'b0,1'b1,1'b1,4'd0,3'd2,3'd1,8'h20,8'hFF,8'h01,BR,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h00,8'h01,3'd2,C0,1'b0,1'b0);
    tbl[15] = mk(1'b0,1'b0,1'b0,4'd2,3'd1,3'd2,8'h60,8'h05,8'h03,BR,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h02,8'h03,3'd1,CA,1'b1,1'b0);
    tbl[16] = mk(1'b0,1'b0,1'b0,4'd11,3'd2,3'd4,8'h20,8'h81,8'h00,BS,1'b0,CA,3'd0,1'b0,8'h00,
                 8'hC0,8'h02,3'd2,CA,1'b1,1'b0);
    tbl[17] = mk(1'b0,1'b0,1'b0,4'd8,3'd3,3'd5,8'h20,8'h80,8'h07,BS,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h00,8'h07,3'd3,CA,1'b1,1'b1);
    tbl[18] = mk(1'b1,1'b0,1'b0,4'd0,3'd3,3'd3,8'h00,8'h00,8'h00,BR,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h00,8'h00,3'd0,C0,1'b0,1'b0);
    tbl[19] = mk(1'b0,1'b0,1'b0,4'd5,3'd4,3'd3,8'h00,8'h3C,8'h00,B0,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h3C,8'h00,3'd4,CA,1'b0,1'b0);
    tbl[20] = mk(1'b0,1'b0,1'b0,4'd13,3'd5,3'd0,8'h00,8'h01,8'h5A,B0,1'b0,CA,3'd0,1'b0,8'h00,
                 8'h00,8'h5A,3'd5,CA,1'b0,1'b0);
    tbl[21] = mk(1'b0,1'b0,1'b0,4'd3,3'd6,3'd1,8'h10,8'h10,8'h00,BC,1'b1,CA,3'd0,1'b0,8'h00,
                 8'hFF,8'h00,3'd6,CA,1'b0,1'b0);

    for (int i = 0; i < NT; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      model_step(tbl[i]);
      check_all(i, tbl[i].e_res, tbl[i].e_store,
                tbl[i].e_rd, tbl[i].e_ctrl,
                tbl[i].e_c, tbl[i].e_z);
    end

    for (int i = 0; i < 500; i++) begin
      vec_t v;
      v = rnd();
      drive(v);
      @(posedge clk);
      #1;
      model_step(v);
      check_all(1000 + i, m_res, m_store, m_rd,
                m_ctrl, m_c, m_z);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
